// File: rtl/mul_operand_sequencer.sv
//------------------------------------------------------------------------------
// Module   : mul_operand_sequencer
// Purpose  : Host-side feeder for the serial signed multiplier. Takes one
//            parallel operand pair over valid/ready, shifts both operands out
//            LSB first with sx/sy framing, requests the multiply, and returns
//            the parallel product as a one-cycle result strobe.
// Options  : `define MUL_SEQ_TIMEOUT_EN adds a watchdog over WAIT_F/MUL, an
//            ERR state and the o_timeout_err output.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mul_operand_sequencer #(
  parameter int XW          = 11,
  parameter int YW          = 12,
  parameter int ZW          = 23,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [XW-1:0] i_x_in,
  input  logic [YW-1:0] i_y_in,
  output logic          o_x,
  output logic          o_y,
  output logic          o_sx,
  output logic          o_sy,
  output logic          o_mul,
  input  logic          i_fx,
  input  logic          i_fy,
  input  logic          i_unsigned_done,
  input  logic [ZW-1:0] i_z_par_in,
  output logic          o_res_valid,
  output logic [ZW-1:0] o_res_z,
`ifdef MUL_SEQ_TIMEOUT_EN
  output logic          o_timeout_err,
`endif
  output logic          o_busy
);

  // Bit counter must hold YW-1 and the XW compare value without truncation.
  localparam int CW = $clog2(YW + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHIFT  = 3'd1,
    S_WAIT_F = 3'd2,
    S_MUL    = 3'd3,
    S_RESULT = 3'd4
`ifdef MUL_SEQ_TIMEOUT_EN
    ,
    S_ERR    = 3'd5
`endif
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  // The LSB of each shift register is the serial output bit itself, so the
  // serial data is registered and aligned with the registered enables.
  logic [XW-1:0]   r_xs;
  logic [YW-1:0]   r_ys;
  logic [CW-1:0]   r_cnt;
  logic            r_sx;
  logic            r_sy;
  logic [ZW-1:0]   r_res_z;

  logic [XW-1:0]   w_xs_nxt;
  logic [YW-1:0]   w_ys_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_sx_nxt;
  logic            w_sy_nxt;
  logic            w_capture;

`ifdef MUL_SEQ_TIMEOUT_EN
  logic [7:0]      r_wd;
  logic            w_wd_run;
  logic            w_wd_expired;

  assign w_wd_run     = (r_state == S_WAIT_F) || (r_state == S_MUL);
  assign w_wd_expired = w_wd_run && (r_wd == 8'(TIMEOUT_CYC - 1));

  // Watchdog: counts every cycle spent waiting on the multiplier, cleared elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd <= '0;
    end else if (w_wd_run) begin
      r_wd <= r_wd + 8'd1;
    end else begin
      r_wd <= '0;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic plus next values of the shift/framing registers.
  always_comb begin
    w_state_nxt = r_state;
    w_xs_nxt    = r_xs;
    w_ys_nxt    = r_ys;
    w_cnt_nxt   = r_cnt;
    w_cnt_inc   = r_cnt + 1'b1;
    w_sx_nxt    = 1'b0;
    w_sy_nxt    = 1'b0;
    w_capture   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_in_valid) begin
          // Bit 0 of both operands is presented in the very next cycle.
          w_state_nxt = S_SHIFT;
          w_xs_nxt    = i_x_in;
          w_ys_nxt    = i_y_in;
          w_cnt_nxt   = '0;
          w_sx_nxt    = 1'b1;
          w_sy_nxt    = 1'b1;
        end
      end

      S_SHIFT: begin
        if (r_cnt == CW'(YW - 1)) begin
          // Last Y bit is on the wire now; park the lines low.
          w_state_nxt = S_WAIT_F;
          w_xs_nxt    = '0;
          w_ys_nxt    = '0;
          w_cnt_nxt   = '0;
        end else begin
          // X runs out first; zeros shifted in keep x low once sx drops.
          w_xs_nxt    = r_xs >> 1;
          w_ys_nxt    = r_ys >> 1;
          w_cnt_nxt   = w_cnt_inc;
          w_sx_nxt    = (w_cnt_inc < CW'(XW));
          w_sy_nxt    = 1'b1;
        end
      end

      S_WAIT_F: begin
        // Always at least one cycle here, even if fx/fy were already high.
        if (i_fx && i_fy) begin
          w_state_nxt = S_MUL;
        end
      end

      S_MUL: begin
        if (i_unsigned_done) begin
          w_state_nxt = S_RESULT;
          w_capture   = 1'b1;
        end
      end

      S_RESULT: begin
        w_state_nxt = S_IDLE;
      end

`ifdef MUL_SEQ_TIMEOUT_EN
      S_ERR: begin
        // Sticky until reset.
        w_state_nxt = S_ERR;
      end
`endif

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

`ifdef MUL_SEQ_TIMEOUT_EN
    // Watchdog expiry overrides any completion in the same cycle.
    if (w_wd_expired) begin
      w_state_nxt = S_ERR;
      w_capture   = 1'b0;
    end
`endif
  end

  // Operand shift registers, framing enables and the product capture register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xs    <= '0;
      r_ys    <= '0;
      r_cnt   <= '0;
      r_sx    <= 1'b0;
      r_sy    <= 1'b0;
      r_res_z <= '0;
    end else begin
      r_xs  <= w_xs_nxt;
      r_ys  <= w_ys_nxt;
      r_cnt <= w_cnt_nxt;
      r_sx  <= w_sx_nxt;
      r_sy  <= w_sy_nxt;
      if (w_capture) begin
        r_res_z <= i_z_par_in;
      end
    end
  end

  assign o_x         = r_xs[0];
  assign o_y         = r_ys[0];
  assign o_sx        = r_sx;
  assign o_sy        = r_sy;
  assign o_res_z     = r_res_z;
  assign o_in_ready  = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_mul       = (r_state == S_MUL);
  assign o_res_valid = (r_state == S_RESULT);
`ifdef MUL_SEQ_TIMEOUT_EN
  assign o_timeout_err = (r_state == S_ERR);
`endif

endmodule

`default_nettype wire

// File: tb/tb_mul_operand_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_mul_operand_sequencer
// Purpose  : Self-checking bench for mul_operand_sequencer. A behavioural
//            multiplier collects the serial bits, raises fx/fy one cycle after
//            the last bit and done five cycles after mul, and returns the
//            signed product. Results are compared against plain arithmetic.
// Options  : honours `define MUL_SEQ_TIMEOUT_EN (watchdog test added).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mul_operand_sequencer;

  localparam int XW  = 11;
  localparam int YW  = 12;
  localparam int ZW  = 23;
  localparam int TO  = 64;
  // Accept edge -> res_valid cycle: 12 SHIFT + 1 WAIT_F + 6 MUL cycles
  // (done is first high in the 6th MUL cycle and sampled at its end).
  localparam int LAT = 19;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [XW-1:0] x_in;
  logic [YW-1:0] y_in;
  logic          in_ready, x, y, sx, sy, mul, res_valid, busy;
  logic          fx, fy, unsigned_done;
  logic [ZW-1:0] z_par_in, res_z;
`ifdef MUL_SEQ_TIMEOUT_EN
  logic          timeout_err;
`endif

  mul_operand_sequencer #(.XW(XW), .YW(YW), .ZW(ZW), .TIMEOUT_CYC(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_in_valid      (in_valid),
    .o_in_ready      (in_ready),
    .i_x_in          (x_in),
    .i_y_in          (y_in),
    .o_x             (x),
    .o_y             (y),
    .o_sx            (sx),
    .o_sy            (sy),
    .o_mul           (mul),
    .i_fx            (fx),
    .i_fy            (fy),
    .i_unsigned_done (unsigned_done),
    .i_z_par_in      (z_par_in),
    .o_res_valid     (res_valid),
    .o_res_z         (res_z),
`ifdef MUL_SEQ_TIMEOUT_EN
    .o_timeout_err   (timeout_err),
`endif
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [ZW-1:0] prod(input logic [XW-1:0] a, input logic [YW-1:0] b);
    logic signed [ZW-1:0] p;
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  // ---------------- behavioural serial multiplier ----------------
  int            xcnt = 0, ycnt = 0, mcnt = 0;
  logic [XW-1:0] xv = '0;
  logic [YW-1:0] yv = '0;
  logic          m_fx = 1'b0, m_fy = 1'b0, m_done = 1'b0;
  logic [ZW-1:0] m_z = '0;
  logic          en_done = 1'b1, spur_idle = 1'b0, spur_en = 1'b0;
  logic          spur;
  logic [ZW-1:0] junk = 23'h2A5A5A;

  assign spur          = spur_idle | (spur_en & sx & (xcnt < 4));
  assign fx            = m_fx;
  assign fy            = m_fy;
  assign unsigned_done = m_done | spur;
  assign z_par_in      = spur ? junk : m_z;

  always @(negedge clk) begin
    if (!rst_n || in_ready) begin
      xcnt = 0; ycnt = 0; mcnt = 0;
      m_fx = 1'b0; m_fy = 1'b0; m_done = 1'b0;
      xv = '0; yv = '0;
    end else begin
      m_fx = (xcnt == XW);
      m_fy = (ycnt == YW);
      if (sx && xcnt < XW) begin xv[xcnt] = x; xcnt++; end
      if (sy && ycnt < YW) begin yv[ycnt] = y; ycnt++; end
      if (mul) begin
        m_done = en_done && (mcnt >= 5);
        mcnt++;
      end else begin
        m_done = 1'b0;
      end
      m_z = prod(xv, yv);
    end
  end

  // ---------------- one complete transaction ----------------
  task automatic run_op(input logic [XW-1:0] xa, input logic [YW-1:0] ya,
                        input logic [ZW-1:0] ez, input bit hold,
                        input logic [XW-1:0] xn, input logic [YW-1:0] yn,
                        input string tag);
    int sxc, syc, lat, bad_rdy, k;
    bit got;
    @(negedge clk);
    x_in = xa; y_in = ya; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    if (!in_ready) begin
      check({tag, " accept"}, 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (hold) begin x_in = xn; y_in = yn; end
    else in_valid = 1'b0;
    sxc = 0; syc = 0; lat = -1; bad_rdy = 0; got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      if (c == 0) check({tag, " first_x"}, 32'(x), 32'(xa[0]));
      sxc += int'(sx);
      syc += int'(sy);
      if (in_ready) bad_rdy++;
      if (res_valid) begin
        got = 1'b1;
        lat = c;
        check({tag, " res_z"}, 32'(res_z), 32'(ez));
        check({tag, " mul_low_at_result"}, 32'(mul), 32'd0);
        check({tag, " serial_x"}, 32'(xv), 32'(xa));
        check({tag, " serial_y"}, 32'(yv), 32'(ya));
      end else begin
        @(posedge clk); #1;
      end
    end
    check({tag, " got_result"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(LAT));
    check({tag, " sx_cycles"}, 32'(sxc), 32'(XW));
    check({tag, " sy_cycles"}, 32'(syc), 32'(YW));
    check({tag, " ready_while_busy"}, 32'(bad_rdy), 32'd0);
    @(posedge clk); #1;
    check({tag, " res_valid_one_cycle"}, 32'(res_valid), 32'd0);
    check({tag, " ready_after"}, 32'(in_ready), 32'd1);
    check({tag, " res_z_held"}, 32'(res_z), 32'(ez));
  endtask

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [ZW-1:0] z;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [XW-1:0] xr;
    logic [YW-1:0] yr;
    logic [ZW-1:0] last_z;
    int c;

    vecs[0] = '{x: 11'h003, y: 12'h005, z: 23'h00000F};
    vecs[1] = '{x: 11'h7FD, y: 12'h005, z: 23'h7FFFF1};
    vecs[2] = '{x: 11'h3FF, y: 12'h7FF, z: 23'h1FF401};
    vecs[3] = '{x: 11'h400, y: 12'h800, z: 23'h200000};
    vecs[4] = '{x: 11'h400, y: 12'h7FF, z: 23'h600400};
    vecs[5] = '{x: 11'h7FF, y: 12'h800, z: 23'h000800};

    rst_n = 1'b0; in_valid = 1'b0; x_in = '0; y_in = '0;
    repeat (3) @(negedge clk);
    check("reset sx",        32'(sx),        32'd0);
    check("reset sy",        32'(sy),        32'd0);
    check("reset x",         32'(x),         32'd0);
    check("reset y",         32'(y),         32'd0);
    check("reset mul",       32'(mul),       32'd0);
    check("reset res_valid", 32'(res_valid), 32'd0);
    check("reset busy",      32'(busy),      32'd0);
    check("reset res_z",     32'(res_z),     32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready after reset", 32'(in_ready), 32'd1);

    // Directed vectors.
    for (int i = 0; i < 6; i++)
      run_op(vecs[i].x, vecs[i].y, vecs[i].z, 1'b0, '0, '0, $sformatf("vec%0d", i));
    last_z = vecs[5].z;

    // in_valid held across two pairs: second pair taken only once IDLE returns.
    run_op(11'd12, 12'hFF9, prod(11'd12, 12'hFF9), 1'b1, 11'h6AB, 12'h3C4, "hold_a");
    run_op(11'h6AB, 12'h3C4, prod(11'h6AB, 12'h3C4), 1'b0, '0, '0, "hold_b");
    last_z = prod(11'h6AB, 12'h3C4);

    // Reset asserted while bit 6 is on the wire.
    @(negedge clk);
    x_in = 11'h155; y_in = 12'hAAA; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("pre-reset sx", 32'(sx), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst sx",    32'(sx),    32'd0);
    check("midrst sy",    32'(sy),    32'd0);
    check("midrst x",     32'(x),     32'd0);
    check("midrst y",     32'(y),     32'd0);
    check("midrst mul",   32'(mul),   32'd0);
    check("midrst busy",  32'(busy),  32'd0);
    check("midrst res_z", 32'(res_z), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(11'h0AB, 12'hF37, prod(11'h0AB, 12'hF37), 1'b0, '0, '0, "after_rst");
    last_z = prod(11'h0AB, 12'hF37);

    // Spurious done while idle: no strobe, no capture.
    @(negedge clk);
    spur_idle = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("spur_idle res_valid", 32'(res_valid), 32'd0);
    end
    @(negedge clk);
    spur_idle = 1'b0;
    check("spur_idle res_z", 32'(res_z), 32'(last_z));
    // Spurious done during the first SHIFT cycles.
    spur_en = 1'b1;
    run_op(11'h2E1, 12'h19C, prod(11'h2E1, 12'h19C), 1'b0, '0, '0, "spur_shift");
    spur_en = 1'b0;

    // Randomised pairs against plain signed multiplication.
    for (int i = 0; i < 16; i++) begin
      xr = XW'($urandom);
      yr = YW'($urandom);
      run_op(xr, yr, prod(xr, yr), 1'b0, '0, '0, $sformatf("rand%0d", i));
    end

`ifdef MUL_SEQ_TIMEOUT_EN
    // Multiplier never finishes: ERR 64 cycles after WAIT_F entry.
    en_done = 1'b0;
    @(negedge clk);
    x_in = 11'h011; y_in = 12'h022; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    c = 0;
    while (!timeout_err && c < 300) begin @(posedge clk); #1; c++; end
    check("timeout cycle", 32'(c), 32'(YW + TO));
    check("err busy",      32'(busy),      32'd1);
    check("err in_ready",  32'(in_ready),  32'd0);
    check("err mul",       32'(mul),       32'd0);
    check("err res_valid", 32'(res_valid), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("err sticky", 32'(timeout_err), 32'd1);
    rst_n = 1'b0;
    #1;
    check("err cleared", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en_done = 1'b1;
    run_op(11'h033, 12'h044, prod(11'h033, 12'h044), 1'b0, '0, '0, "after_err");
`else
    c = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
